alarm_programmer: RTL and testbench
===================================

// Module: alarm_programmer
// PURPOSE
//  Button-driven controller that programs and arms the alarm value matcher.
//  Edits an HH:MM BCD alarm time, then commits it with a one-cycle set_value pulse.
//  Issues turn_on / turn_off pulses to arm or disarm the alarm.
//  Outside commit cycles, it passes the running clock time through to the matcher's compare input.
// PARAMETERS
//  HOUR_MAX   23     last hour value before wrap to 00 (BCD, decimal meaning)
//  MIN_MAX    59     last minute value before wrap to 00
//  TIMEOUT    1000   idle clk cycles in an edit state before edit is abandoned (>=2)
// PORTS
//  clk         in   1   system clock, all logic on posedge
//  rst         in   1   synchronous reset, active-low (rst==0 resets on posedge clk)
//  btn_mode    in   1   debounced 1-cycle pulse: enter edit / next field / commit
//  btn_inc     in   1   debounced 1-cycle pulse: increment field being edited
//  btn_alarm   in   1   debounced 1-cycle pulse: toggle alarm armed state
//  alarm_cur   in   16  current stored alarm {Hh,Hl,Mh,Ml} BCD, from matcher value_out
//  alarm_on    in   1   current armed state, from matcher turn_out
//  time_in     in   16  running clock time {Hh,Hl,Mh,Ml} BCD
//  value_out   out  16  to matcher value_in: edit value when set_value=1, else time_in
//  set_value   out  1   1-cycle commit strobe to matcher
//  turn_on     out  1   1-cycle arm strobe
//  turn_off    out  1   1-cycle disarm strobe
//  edit_sel    out  2   display hint: 00 none, 01 hours, 10 minutes
// BEHAVIOUR
//  - States: IDLE, EDIT_H, EDIT_M, COMMIT. Transitions happen on posedge clk.
//  - Reset (rst==0): state=IDLE, edit_h=edit_m=8'h00, timer=0.
//    set_value=turn_on=turn_off=0, edit_sel=00.
//    value_out follows time_in during reset.
//  - IDLE, btn_mode: load edit_h=alarm_cur[15:8], edit_m=alarm_cur[7:0]; go to EDIT_H.
//  - IDLE, btn_alarm (no btn_mode): next cycle pulse turn_off if alarm_on=1, else turn_on.
//    Exactly one of the two strobes, high for 1 cycle.
//  - IDLE, btn_mode and btn_alarm together: btn_mode wins; the toggle is dropped.
//  - EDIT_H, btn_inc: edit_h += 1 in BCD; if edit_h==HOUR_MAX, wrap to 00.
//    Low digit 9 carries to the high digit (09->10, 19->20).
//  - EDIT_H, btn_mode: go to EDIT_M.
//  - EDIT_M, btn_inc: edit_m += 1 in BCD, wrap MIN_MAX->00.
//  - EDIT_M, btn_mode: go to COMMIT.
//  - btn_mode and btn_inc in the same cycle: mode wins; no increment.
//  - btn_alarm in any edit state: ignored.
//  - COMMIT (1 cycle): set_value=1, value_out={edit_h,edit_m}, turn_on=1; then IDLE.
//    Committing always arms the alarm; turn_off is never asserted with turn_on.
//  - Strobes are registered, so a strobe appears 1 cycle after the causing button/state.
//    set_value is high exactly during the COMMIT state cycle.
//  - value_out is combinational: set_value ? {edit_h,edit_m} : time_in.
//  - Timeout: timer clears on entering EDIT_H and on any btn_mode/btn_inc while editing.
//    Otherwise it increments each cycle in EDIT_H/EDIT_M.
//    When timer reaches TIMEOUT-1: go to IDLE with no set_value and no turn_on.
//    The stored alarm is unchanged.
//  - Reset mid-edit or in COMMIT: immediate IDLE; a pending set_value/turn_on is suppressed.
//  - edit_sel: 01 in EDIT_H, 10 in EDIT_M, 00 otherwise.
//  - Edit registers never hold an invalid BCD value, provided alarm_cur is valid BCD.
// TESTING
//  1 Release rst with buttons idle -> all strobes 0, edit_sel=00, value_out==time_in (e.g. 16'h1234).
//  2 alarm_cur=16'h0745.
//    Send mode, inc x3, mode, inc x15, mode.
//    -> set_value 1 cycle with value_out=16'h1000, turn_on 1 cycle together, then IDLE.
//  3 Wrap: alarm_cur=16'h2359; mode, inc, mode, inc, mode -> commit value_out=16'h0000.
//    Carry: 16'h0959 +1h -> 16'h1059.
//  4 Toggle: btn_alarm with alarm_on=0 -> turn_on pulse only.
//    With alarm_on=1 -> turn_off pulse only.
//    btn_alarm in EDIT_M -> no strobe.
//  5 TIMEOUT=8: mode, then 7 idle cycles -> IDLE, edit_sel=00, no set_value/turn_on.
//    An inc at cycle 6 restarts the count.
//  6 Simultaneous: mode+inc in EDIT_H -> EDIT_M, hour unchanged.
//    rst=0 in COMMIT cycle -> no set_value next cycle.

Source files
------------

// File: rtl/alarm_programmer.sv
// Button-driven editor for the alarm matcher: edits an HH:MM BCD alarm, commits it
// with a one-cycle set_value strobe, and arms/disarms the alarm with turn_on/turn_off.
module alarm_programmer #(
    parameter int HOUR_MAX = 23,
    parameter int MIN_MAX  = 59,
    parameter int TIMEOUT  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_alarm,
    input  logic [15:0] alarm_cur,
    input  logic        alarm_on,
    input  logic [15:0] time_in,
    output logic [15:0] value_out,
    output logic        set_value,
    output logic        turn_on,
    output logic        turn_off,
    output logic [1:0]  edit_sel
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT_H = 2'd1,
        EDIT_M = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int             TW           = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TIMER_LAST   = TW'(TIMEOUT - 2);
    localparam logic [7:0]     HOUR_MAX_BCD = 8'(((HOUR_MAX / 10) << 4) | (HOUR_MAX % 10));
    localparam logic [7:0]     MIN_MAX_BCD  = 8'(((MIN_MAX / 10) << 4) | (MIN_MAX % 10));

    state_t        state_q, state_d;
    logic [7:0]    edit_h_q, edit_h_d;
    logic [7:0]    edit_m_q, edit_m_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          tog_on_q, tog_on_d;
    logic          tog_off_q, tog_off_d;
    logic          commit_act;

    // Two-digit BCD increment with wrap at the field's maximum value.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_bcd);
        logic [7:0] r;
        if (v == max_bcd) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            edit_h_q  <= 8'h00;
            edit_m_q  <= 8'h00;
            timer_q   <= '0;
            tog_on_q  <= 1'b0;
            tog_off_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            edit_h_q  <= edit_h_d;
            edit_m_q  <= edit_m_d;
            timer_q   <= timer_d;
            tog_on_q  <= tog_on_d;
            tog_off_q <= tog_off_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        edit_h_d  = edit_h_q;
        edit_m_d  = edit_m_q;
        timer_d   = timer_q;
        tog_on_d  = 1'b0;
        tog_off_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_mode) begin
                    edit_h_d = alarm_cur[15:8];
                    edit_m_d = alarm_cur[7:0];
                    timer_d  = '0;
                    state_d  = EDIT_H;
                end else if (btn_alarm) begin
                    tog_on_d  = ~alarm_on;
                    tog_off_d = alarm_on;
                end
            end
            EDIT_H: begin
                if (btn_mode) begin
                    timer_d = '0;
                    state_d = EDIT_M;
                end else if (btn_inc) begin
                    edit_h_d = bcd_inc(edit_h_q, HOUR_MAX_BCD);
                    timer_d  = '0;
                end else if (timer_q == TIMER_LAST) begin
                    // Idle too long: abandon the edit without committing.
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            EDIT_M: begin
                if (btn_mode) begin
                    timer_d = '0;
                    state_d = COMMIT;
                end else if (btn_inc) begin
                    edit_m_d = bcd_inc(edit_m_q, MIN_MAX_BCD);
                    timer_d  = '0;
                end else if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are masked while reset is held so a commit/toggle caught mid-reset never leaks.
    assign commit_act = (state_q == COMMIT) && rst;
    assign set_value  = commit_act;
    assign turn_on    = (tog_on_q && rst) || commit_act;
    assign turn_off   = tog_off_q && rst;
    assign value_out  = set_value ? {edit_h_q, edit_m_q} : time_in;

    always_comb begin
        case (state_q)
            EDIT_H:  edit_sel = 2'b01;
            EDIT_M:  edit_sel = 2'b10;
            default: edit_sel = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_alarm_programmer.sv
// Directed bench for alarm_programmer: editing, BCD wrap/carry, toggling, timeout, reset.
module tb_alarm_programmer;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_mode, btn_inc, btn_alarm;
    logic [15:0] alarm_cur;
    logic        alarm_on;
    logic [15:0] time_in;
    logic [15:0] value_out;
    logic        set_value, turn_on, turn_off;
    logic [1:0]  edit_sel;

    int tests_run    = 0;
    int tests_failed = 0;

    alarm_programmer #(
        .HOUR_MAX(23),
        .MIN_MAX (59),
        .TIMEOUT (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .btn_alarm(btn_alarm),
        .alarm_cur(alarm_cur),
        .alarm_on (alarm_on),
        .time_in  (time_in),
        .value_out(value_out),
        .set_value(set_value),
        .turn_on  (turn_on),
        .turn_off (turn_off),
        .edit_sel (edit_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] check %-24s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic i, input logic a);
        btn_mode  = m;
        btn_inc   = i;
        btn_alarm = a;
        tick();
        btn_mode  = 1'b0;
        btn_inc   = 1'b0;
        btn_alarm = 1'b0;
    endtask

    // Checks the cycle in which the commit strobe should be visible, then the cycle after.
    task automatic chk_commit(input string tag, input logic [15:0] exp_val);
        chk({tag, "_set"},  {15'd0, set_value}, 16'd1);
        chk({tag, "_on"},   {15'd0, turn_on},   16'd1);
        chk({tag, "_off"},  {15'd0, turn_off},  16'd0);
        chk({tag, "_val"},  value_out,          exp_val);
        tick();
        chk({tag, "_set0"}, {15'd0, set_value}, 16'd0);
        chk({tag, "_on0"},  {15'd0, turn_on},   16'd0);
        chk({tag, "_pass"}, value_out,          time_in);
    endtask

    initial begin
        rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_alarm = 1'b0;
        alarm_cur = 16'h0000; alarm_on = 1'b0; time_in = 16'h1234;

        // 1: reset and release
        tick(); tick();
        chk("rst_value_out", value_out, 16'h1234);
        chk("rst_set_value", {15'd0, set_value}, 16'd0);
        rst = 1'b1;
        tick();
        chk("idle_strobes", {13'd0, set_value, turn_on, turn_off}, 16'd0);
        chk("idle_edit_sel", {14'd0, edit_sel}, 16'd0);
        chk("idle_value_out", value_out, 16'h1234);

        // 2: 07:45 -> +3h -> 10, +15m -> 00 wraps, commit 10:00
        alarm_cur = 16'h0745;
        press(1, 0, 0);
        chk("edit_h_sel", {14'd0, edit_sel}, 16'd1);
        for (int k = 0; k < 3; k++) press(0, 1, 0);
        press(1, 0, 0);
        chk("edit_m_sel", {14'd0, edit_sel}, 16'd2);
        for (int k = 0; k < 15; k++) press(0, 1, 0);
        chk("edit_m_noset", {15'd0, set_value}, 16'd0);
        press(1, 0, 0);
        chk("commit_sel", {14'd0, edit_sel}, 16'd0);
        chk_commit("c1000", 16'h1000);

        // 3: wrap 23:59 -> 00:00, and carry 09:59 -> 10:59
        alarm_cur = 16'h2359;
        press(1, 0, 0); press(0, 1, 0); press(1, 0, 0); press(0, 1, 0); press(1, 0, 0);
        chk_commit("c0000", 16'h0000);
        time_in = 16'h0815;
        alarm_cur = 16'h0959;
        press(1, 0, 0); press(0, 1, 0); press(1, 0, 0); press(1, 0, 0);
        chk_commit("c1059", 16'h1059);

        // 4: alarm toggle
        alarm_on = 1'b0;
        press(0, 0, 1);
        chk("tog_on_on",  {15'd0, turn_on},  16'd1);
        chk("tog_on_off", {15'd0, turn_off}, 16'd0);
        tick();
        chk("tog_on_end", {15'd0, turn_on},  16'd0);
        alarm_on = 1'b1;
        press(0, 0, 1);
        chk("tog_off_off", {15'd0, turn_off}, 16'd1);
        chk("tog_off_on",  {15'd0, turn_on},  16'd0);
        tick();
        chk("tog_off_end", {15'd0, turn_off}, 16'd0);
        alarm_cur = 16'h0130;
        press(1, 0, 0); press(1, 0, 0);
        press(0, 0, 1);
        chk("editm_alarm", {14'd0, turn_on, turn_off}, 16'd0);
        chk("editm_stay",  {14'd0, edit_sel}, 16'd2);
        press(1, 0, 0);
        chk_commit("c0130", 16'h0130);
        press(1, 0, 1);
        chk("mode_alarm_sel", {14'd0, edit_sel}, 16'd1);
        chk("mode_alarm_str", {14'd0, turn_on, turn_off}, 16'd0);

        // 5: timeout with TIMEOUT=8 (already in EDIT_H, timer just cleared)
        for (int k = 0; k < 6; k++) tick();
        chk("to_before", {14'd0, edit_sel}, 16'd1);
        tick();
        chk("to_idle_sel", {14'd0, edit_sel}, 16'd0);
        chk("to_idle_str", {14'd0, set_value, turn_on}, 16'd0);
        press(1, 0, 0);
        for (int k = 0; k < 5; k++) tick();
        press(0, 1, 0);
        for (int k = 0; k < 6; k++) tick();
        chk("to_restart", {14'd0, edit_sel}, 16'd1);
        tick();
        chk("to_restart_idle", {14'd0, edit_sel}, 16'd0);
        chk("to_restart_str", {14'd0, set_value, turn_on}, 16'd0);

        // 6: mode+inc in EDIT_H, then reset during COMMIT
        alarm_cur = 16'h0745;
        press(1, 0, 0);
        press(1, 1, 0);
        chk("modeinc_sel", {14'd0, edit_sel}, 16'd2);
        press(1, 0, 0);
        chk_commit("c0745", 16'h0745);
        press(1, 0, 0); press(0, 1, 0); press(1, 0, 0); press(1, 0, 0);
        rst = 1'b0;
        #1;
        chk("rstc_set", {15'd0, set_value}, 16'd0);
        chk("rstc_val", value_out, time_in);
        tick();
        chk("rstc_next", {13'd0, set_value, turn_on, turn_off}, 16'd0);
        chk("rstc_sel",  {14'd0, edit_sel}, 16'd0);
        rst = 1'b1;
        tick();
        chk("rstc_after", {15'd0, set_value}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
